led_mirror_master: RTL and testbench



---
 rtl/led_mirror_master_pkg.sv | 16 +
 rtl/led_mirror_master_interval_timer.sv | 34 +++
 rtl/led_mirror_master.sv | 111 +++++++++++
 tb/tb_led_mirror_master.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_mirror_master_pkg.sv
// Shared types and constants for the LED mirror master and its helpers.
package led_mirror_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq
  } state_e;

  localparam logic [3:0] AvalonByteEn = 4'hF;

  // Data register offset within a parallel-port slave's address window.
  localparam logic [1:0] PpDataOffset = 2'h0;

endpackage

// File: rtl/led_mirror_master_interval_timer.sv
// Free-running 0..PERIOD-1 counter with a single-cycle tick on the last count.
module led_mirror_master_interval_timer #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LastCount = CW'(PERIOD - 1);

  logic [CW-1:0] count_q, count_d;

  // Held at zero while disabled so a re-enable always waits a full period.
  always_comb begin
    count_d = '0;
    if (enable && (count_q != LastCount)) begin
      count_d = count_q + CW'(1);
    end
  end

  assign tick = enable && (count_q == LastCount);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_mirror_master.sv
// Avalon-MM initiator that periodically copies a source port data register to a
// destination port data register, optionally inverting the value.
module led_mirror_master
  import led_mirror_master_pkg::*;
#(
  parameter int unsigned DW       = 7,
  parameter logic [31:0] SRC_ADDR = 32'h0000_1000,
  parameter logic [31:0] DST_ADDR = 32'h0000_2000,
  parameter int unsigned PERIOD   = 50000,
  parameter bit          INVERT   = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic [31:0]   m_address,
  output logic [3:0]    m_byteenable,
  output logic          m_read,
  output logic          m_write,
  output logic [31:0]   m_writedata,
  input  logic [31:0]   m_readdata,
  input  logic          m_waitrequest,
  output logic          busy,
  output logic [DW:0]   last_value,
  output logic [15:0]   xfer_count
);

  state_e        state_q, state_d;
  logic [DW:0]   data_q, data_d;
  logic [DW:0]   last_value_q, last_value_d;
  logic [15:0]   xfer_count_q, xfer_count_d;
  logic          tick;
  logic          unused_rdata;

  assign unused_rdata = ^m_readdata[31:DW+1];

  led_mirror_master_interval_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      data_q       <= '0;
      last_value_q <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      last_value_q <= last_value_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // Ticks arriving outside StIdle are simply lost; no request is queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (tick) state_d = StRdReq;
      StRdReq:  if (!m_waitrequest) state_d = StRdWait;
      StRdWait: state_d = StWrReq;
      StWrReq:  if (!m_waitrequest) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d       = data_q;
    last_value_d = last_value_q;
    xfer_count_d = xfer_count_q;
    if (state_q == StRdWait) begin
      data_d = INVERT ? ~m_readdata[DW:0] : m_readdata[DW:0];
    end
    if ((state_q == StWrReq) && !m_waitrequest) begin
      last_value_d = data_q;
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  // Command outputs decode from state only, so they hold steady under stall.
  always_comb begin
    m_address    = '0;
    m_byteenable = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = '0;
    unique case (state_q)
      StRdReq: begin
        m_read       = 1'b1;
        m_address    = SRC_ADDR | 32'(PpDataOffset);
        m_byteenable = AvalonByteEn;
      end
      StWrReq: begin
        m_write      = 1'b1;
        m_address    = DST_ADDR | 32'(PpDataOffset);
        m_writedata  = 32'(data_q);
        m_byteenable = AvalonByteEn;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign last_value = last_value_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_led_mirror_master.sv
// Bench: slave model plus scoreboard around a plain and an inverting instance.
module tb_led_mirror_master;

  localparam int unsigned P = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  logic [31:0] m_address, i_address;
  logic [3:0]  m_byteenable, i_byteenable;
  logic        m_read, i_read, m_write, i_write, busy, i_busy;
  logic [31:0] m_writedata, i_writedata;
  logic [7:0]  last_value, i_last_value;
  logic [15:0] xfer_count, i_xfer_count;

  always #5 clk = ~clk;

  led_mirror_master #(.PERIOD(P), .INVERT(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(busy), .last_value(last_value),
    .xfer_count(xfer_count)
  );

  led_mirror_master #(.PERIOD(P), .INVERT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(i_address), .m_byteenable(i_byteenable), .m_read(i_read),
    .m_write(i_write), .m_writedata(i_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest), .busy(i_busy), .last_value(i_last_value),
    .xfer_count(i_xfer_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] inv_q[$];
  logic [7:0]  next_data;
  int          rd_stall_cfg, wr_stall_cfg;

  int          cyc, rd_left, wr_left, rd_waits, wr_waits, busy_len, last_len;
  int          rd_acc, wr_acc, rd_acc_cyc, prev_start;
  bit          gap_valid, pend, prev_busy, prev_hold;
  logic [1:0]  prev_rw;
  logic [31:0] prev_addr, prev_wd;
  logic [3:0]  prev_be;
  logic [15:0] exp_count;
  logic [7:0]  exp_last;

  initial begin
    cyc = 0; rd_acc = 0; wr_acc = 0;
  end

  // Slave model and monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [31:0] w, wi;
    cyc++;
    if (!reset_n) begin
      m_waitrequest = 1'b0;
      m_readdata    = {24'hC3C3C3, next_data};
      rd_left = rd_stall_cfg; wr_left = wr_stall_cfg;
      rd_waits = 0; wr_waits = 0; busy_len = 0;
      gap_valid = 0; pend = 0; prev_busy = 0; prev_hold = 0;
      exp_count = '0; exp_last = '0;
    end else begin
      if (m_read) begin
        m_waitrequest = (rd_left != 0);
        if (rd_left != 0) begin rd_left--; rd_waits++; end
      end else if (m_write) begin
        m_waitrequest = (wr_left != 0);
        if (wr_left != 0) begin wr_left--; wr_waits++; end
      end else begin
        m_waitrequest = 1'b0;
        rd_left = rd_stall_cfg; wr_left = wr_stall_cfg;
      end
      if (!busy) begin
        m_readdata = {24'hC3C3C3, next_data};
        rd_waits = 0; wr_waits = 0; busy_len = 0;
      end else begin
        busy_len++;
      end
      if (!enable) gap_valid = 0;

      if (pend) begin
        check_eq("xfer_count", 32'(xfer_count), 32'(exp_count));
        check_eq("last_value", 32'(last_value), 32'(exp_last));
        pend = 0;
      end
      if (m_read || m_write) check_eq("rd_wr_excl", 32'(m_read & m_write), 0);
      if (prev_hold) begin
        check_eq("hold_strobe", 32'({m_read, m_write}), 32'(prev_rw));
        check_eq("hold_addr", m_address, prev_addr);
        check_eq("hold_wdata", m_writedata, prev_wd);
        check_eq("hold_be", 32'(m_byteenable), 32'(prev_be));
      end
      if (m_read && !prev_busy) begin
        if (gap_valid) check_eq("tick_gap", cyc - prev_start, P * ((last_len + P) / P));
        prev_start = cyc;
        gap_valid  = enable;
      end
      if (m_read && !m_waitrequest) begin
        check_eq("raddr", m_address, 32'h0000_1000);
        check_eq("rbe", 32'(m_byteenable), 32'hF);
        check_eq("rbe_inv", 32'(i_byteenable), 32'hF);
        exp_q.push_back({24'h0, m_readdata[7:0]});
        inv_q.push_back({24'h0, ~m_readdata[7:0]});
        rd_acc++;
        rd_acc_cyc = cyc;
      end
      if (m_write && !m_waitrequest) begin
        wr_acc++;
        if (exp_q.size() == 0) begin
          check_eq("sb_empty", 1, 0);
        end else begin
          w  = exp_q.pop_front();
          wi = inv_q.pop_front();
          check_eq("wdata", m_writedata, w);
          check_eq("wdata_inv", i_writedata, wi);
          exp_last = w[7:0];
        end
        check_eq("waddr", m_address, 32'h0000_2000);
        check_eq("wbe", 32'(m_byteenable), 32'hF);
        check_eq("wbe_inv", 32'(i_byteenable), 32'hF);
        check_eq("rd2wr_lat", cyc - rd_acc_cyc, 2 + wr_waits);
        check_eq("busy_len", busy_len, rd_waits + wr_waits + 3);
        last_len  = busy_len;
        exp_count = exp_count + 16'd1;
        pend      = 1;
      end
      prev_hold = (m_read || m_write) && m_waitrequest;
      prev_rw   = {m_read, m_write};
      prev_addr = m_address;
      prev_wd   = m_writedata;
      prev_be   = m_byteenable;
      prev_busy = busy;
    end
  end

  task automatic wait_writes(input int n, input string tag);
    int target = wr_acc + n;
    int b = 0;
    while (wr_acc < target && b < 200) begin
      @(negedge clk);
      b++;
    end
    check_eq(tag, 32'(wr_acc >= target), 1);
  endtask

  initial begin
    int b, rd_snap;
    reset_n = 1'b0; enable = 1'b0;
    next_data = 8'hA5; rd_stall_cfg = 0; wr_stall_cfg = 0;
    #3;
    check_eq("rst_read", 32'(m_read), 0);
    check_eq("rst_write", 32'(m_write), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_addr", m_address, 0);
    check_eq("rst_wdata", m_writedata, 0);
    check_eq("rst_be", 32'(m_byteenable), 0);
    check_eq("rst_last", 32'(last_value), 0);
    check_eq("rst_count", 32'(xfer_count), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1; enable = 1'b1;

    // Basic mirror, then read/write stall, then a stall spanning a tick.
    wait_writes(2, "basic_done");
    next_data = 8'h0F; rd_stall_cfg = 5; wr_stall_cfg = 3;
    wait_writes(2, "stall_done");
    next_data = 8'h3C; rd_stall_cfg = 0; wr_stall_cfg = 12;
    wait_writes(2, "drop_done");

    // Enable dropped while in the read-wait cycle.
    next_data = 8'h81; wr_stall_cfg = 0;
    b = 0;
    do begin @(negedge clk); b++; end
    while (!(busy && !m_read && !m_write) && b < 100);
    check_eq("find_rdwait", 32'(b < 100), 1);
    enable = 1'b0;
    rd_snap = rd_acc;
    wait_writes(1, "en_off_write");
    repeat (3 * P) @(negedge clk);
    check_eq("no_new_reads", rd_acc, rd_snap);
    check_eq("wr_matches_rd", wr_acc, rd_acc);

    // Reset asserted while a write is stalled.
    enable = 1'b1; wr_stall_cfg = 4; next_data = 8'h66;
    b = 0;
    do begin @(negedge clk); b++; end
    while (!m_write && b < 100);
    check_eq("find_write", 32'(b < 100), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_write", 32'(m_write), 0);
    check_eq("async_busy", 32'(busy), 0);
    check_eq("async_count", 32'(xfer_count), 0);
    check_eq("async_last", 32'(last_value), 0);
    exp_q.delete(); inv_q.delete();
    enable = 1'b0; wr_stall_cfg = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Counter wrap from a preloaded 16'hFFFF.
    @(negedge clk);
    force dut0.xfer_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut0.xfer_count_q;
    exp_count = 16'hFFFF;
    repeat (2) @(negedge clk);
    check_eq("cnt_preload", 32'(xfer_count), 32'hFFFF);
    next_data = 8'h5A; enable = 1'b1;
    wait_writes(1, "wrap_write");
    @(negedge clk);
    check_eq("cnt_wrap", 32'(xfer_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
